// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one outstanding imem request, IF/ID register with a
// one-entry skid buffer, and next-PC / load-enable generation for the PC register.
module fetch_unit #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc_q,
    output logic [ADDR_W-1:0]  pc_next,
    output logic               pc_load,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               stall,
    output logic               if_valid,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [INSTR_W-1:0] if_instr
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD
    } state_e;

    state_e             state_q, state_d;
    logic               drop_q, drop_d;
    logic               if_valid_q, if_valid_d;
    logic [ADDR_W-1:0]  if_pc_q, if_pc_d;
    logic [INSTR_W-1:0] if_instr_q, if_instr_d;
    logic [ADDR_W-1:0]  skid_pc_q, skid_pc_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;

    logic [ADDR_W-1:0]  pc_inc;
    logic [ADDR_W-1:0]  redirect_target;
    logic               if_free;
    logic               unused_redirect_lsb;

    assign pc_inc              = pc_q + ADDR_W'(4);
    assign redirect_target     = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc[1:0];
    assign if_free             = !if_valid_q || !stall;

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case/if tree can leave a value unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        drop_d       = drop_q;
        if_valid_d   = if_valid_q;
        if_pc_d      = if_pc_q;
        if_instr_d   = if_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        imem_req     = 1'b0;
        imem_addr    = pc_q;
        pc_next      = pc_inc;
        pc_load      = 1'b0;

        // Decode takes the current entry whenever it is not stalled.
        if (if_valid_q && !stall) begin
            if_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = ST_REQ;
                    end else if (if_free) begin
                        if_valid_d = 1'b1;
                        if_pc_d    = pc_q;
                        if_instr_d = imem_rdata;
                        pc_load    = 1'b1;
                        state_d    = ST_REQ;
                    end else begin
                        skid_pc_d    = pc_q;
                        skid_instr_d = imem_rdata;
                        pc_load      = 1'b1;
                        state_d      = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (!stall) begin
                    if_valid_d = 1'b1;
                    if_pc_d    = skid_pc_q;
                    if_instr_d = skid_instr_q;
                    state_d    = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A redirect overrides whatever the state logic decided above.
        if (redirect) begin
            pc_load      = 1'b1;
            pc_next      = redirect_target;
            if_valid_d   = 1'b0;
            skid_pc_d    = '0;
            skid_instr_d = '0;
            case (state_q)
                ST_REQ: begin
                    if (imem_ready) begin
                        drop_d  = 1'b1;
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        drop_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        drop_d  = 1'b1;
                        state_d = ST_WAIT;
                    end
                end
                ST_HOLD: begin
                    state_d = ST_REQ;
                end
                default: begin
                    state_d = ST_REQ;
                end
            endcase
        end

        if (rst) begin
            imem_req = 1'b0;
            pc_load  = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours; reset here is synchronous.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            drop_q       <= 1'b0;
            if_valid_q   <= 1'b0;
            if_pc_q      <= '0;
            if_instr_q   <= '0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            drop_q       <= drop_d;
            if_valid_q   <= if_valid_d;
            if_pc_q      <= if_pc_d;
            if_instr_q   <= if_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
        end
    end

    assign if_valid = if_valid_q;
    assign if_pc    = if_pc_q;
    assign if_instr = if_instr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed cycle-by-cycle bench for fetch_unit; the bench owns the PC register
// (reset to 0, loads pc_next on pc_load) so pc_q follows the DUT's requests.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_q;
    logic [31:0] pc_next;
    logic        pc_load;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (rst)          pc_q <= 32'h0;
        else if (pc_load) pc_q <= pc_next;
    end

    fetch_unit #(.ADDR_W(32), .INSTR_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_q        (pc_q),
        .pc_next     (pc_next),
        .pc_load     (pc_load),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_instr    (if_instr)
    );

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [31:0] rdata;
        logic        rd;
        logic [31:0] rpc;
        logic        st;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_load;
        logic [31:0] e_next;
        logic        e_ifv;
        logic [31:0] e_ifpc;
        logic [31:0] e_instr;
        logic        chk_if;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic rst, input logic rdy, input logic rv, input logic [31:0] rdata,
        input logic rd, input logic [31:0] rpc, input logic st,
        input logic e_req, input logic [31:0] e_addr, input logic e_load,
        input logic [31:0] e_next, input logic e_ifv, input logic [31:0] e_ifpc,
        input logic [31:0] e_instr);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.rv = rv; v.rdata = rdata;
        v.rd = rd; v.rpc = rpc; v.st = st;
        v.e_req = e_req; v.e_addr = e_addr; v.e_load = e_load; v.e_next = e_next;
        v.e_ifv = e_ifv; v.e_ifpc = e_ifpc; v.e_instr = e_instr;
        v.chk_if = e_ifv;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, compare outputs at the falling edge, then clock.
    task automatic apply(input string tag, input vec_t v);
        rst         = v.rst;
        imem_ready  = v.rdy;
        imem_rvalid = v.rv;
        imem_rdata  = v.rdata;
        redirect    = v.rd;
        redirect_pc = v.rpc;
        stall       = v.st;
        @(negedge clk);
        n_vec++;
        check({tag, " imem_req"},  32'(imem_req), 32'(v.e_req));
        check({tag, " imem_addr"}, imem_addr,     v.e_addr);
        check({tag, " pc_load"},   32'(pc_load),  32'(v.e_load));
        check({tag, " pc_next"},   pc_next,       v.e_next);
        check({tag, " if_valid"},  32'(if_valid), 32'(v.e_ifv));
        if (v.chk_if) begin
            check({tag, " if_pc"},    if_pc,    v.e_ifpc);
            check({tag, " if_instr"}, if_instr, v.e_instr);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        //            rst rdy rv rdata         rd rpc           st  req addr          ld next          ifv ifpc          instr
        // sequential fetch 0x0, 0x4, 0x8
        tbl.push_back(mk(0,0,0,32'h0,        0,32'h0,        0,  0,32'h0,        0,32'h4,        0,32'h0,        32'h0));
        tbl.push_back(mk(0,1,0,32'h0,        0,32'h0,        0,  1,32'h0,        0,32'h4,        0,32'h0,        32'h0));
        tbl.push_back(mk(0,0,1,32'hA0,       0,32'h0,        0,  0,32'h0,        1,32'h4,        0,32'h0,        32'h0));
        tbl.push_back(mk(0,1,0,32'h0,        0,32'h0,        0,  1,32'h4,        0,32'h8,        1,32'h0,        32'hA0));
        tbl.push_back(mk(0,0,1,32'hA1,       0,32'h0,        0,  0,32'h4,        1,32'h8,        0,32'h0,        32'h0));
        tbl.push_back(mk(0,1,0,32'h0,        0,32'h0,        0,  1,32'h8,        0,32'hC,        1,32'h4,        32'hA1));
        tbl.push_back(mk(0,0,1,32'hA2,       0,32'h0,        0,  0,32'h8,        1,32'hC,        0,32'h0,        32'h0));
        // variable latency at 0xC: ready after 3 cycles, rvalid 5 cycles after accept
        tbl.push_back(mk(0,0,0,32'h0,        0,32'h0,        0,  1,32'hC,        0,32'h10,       1,32'h8,        32'hA2));
        tbl.push_back(mk(0,0,0,32'h0,        0,32'h0,        0,  1,32'hC,        0,32'h10,       0,32'h0,        32'h0));
        tbl.push_back(mk(0,0,0,32'h0,        0,32'h0,        0,  1,32'hC,        0,32'h10,       0,32'h0,        32'h0));
        tbl.push_back(mk(0,1,0,32'h0,        0,32'h0,        0,  1,32'hC,        0,32'h10,       0,32'h0,        32'h0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0,0,0,32'h0,    0,32'h0,        0,  0,32'hC,        0,32'h10,       0,32'h0,        32'h0));
        tbl.push_back(mk(0,0,1,32'hA3,       0,32'h0,        0,  0,32'hC,        1,32'h10,       0,32'h0,        32'h0));
        // stall with skid: 0xC held while response for 0x10 arrives
        tbl.push_back(mk(0,1,0,32'h0,        0,32'h0,        1,  1,32'h10,       0,32'h14,       1,32'hC,        32'hA3));
        tbl.push_back(mk(0,0,1,32'hA4,       0,32'h0,        1,  0,32'h10,       1,32'h14,       1,32'hC,        32'hA3));
        tbl.push_back(mk(0,0,0,32'h0,        0,32'h0,        1,  0,32'h14,       0,32'h18,       1,32'hC,        32'hA3));
        tbl.push_back(mk(0,0,0,32'h0,        0,32'h0,        0,  0,32'h14,       0,32'h18,       1,32'hC,        32'hA3));
        tbl.push_back(mk(0,1,0,32'h0,        0,32'h0,        0,  1,32'h14,       0,32'h18,       1,32'h10,       32'hA4));
        // redirect to 0x103 during WAIT, late response dropped
        tbl.push_back(mk(0,0,0,32'h0,        1,32'h103,      0,  0,32'h14,       1,32'h100,      0,32'h0,        32'h0));
        tbl.push_back(mk(0,0,1,32'hDEAD,     0,32'h0,        0,  0,32'h100,      0,32'h104,      0,32'h0,        32'h0));
        tbl.push_back(mk(0,1,0,32'h0,        0,32'h0,        0,  1,32'h100,      0,32'h104,      0,32'h0,        32'h0));
        tbl.push_back(mk(0,0,1,32'hB0,       0,32'h0,        0,  0,32'h100,      1,32'h104,      0,32'h0,        32'h0));
        // redirect together with rvalid in WAIT, stall held
        tbl.push_back(mk(0,1,0,32'h0,        0,32'h0,        1,  1,32'h104,      0,32'h108,      1,32'h100,      32'hB0));
        tbl.push_back(mk(0,0,1,32'hBAD,      1,32'h200,      1,  0,32'h104,      1,32'h200,      1,32'h100,      32'hB0));
        tbl.push_back(mk(0,1,0,32'h0,        0,32'h0,        0,  1,32'h200,      0,32'h204,      0,32'h0,        32'h0));
        tbl.push_back(mk(0,0,1,32'hB1,       0,32'h0,        0,  0,32'h200,      1,32'h204,      0,32'h0,        32'h0));
        // redirect in REQ without acceptance
        tbl.push_back(mk(0,0,0,32'h0,        1,32'h300,      0,  1,32'h204,      1,32'h300,      1,32'h200,      32'hB1));
        tbl.push_back(mk(0,1,0,32'h0,        0,32'h0,        0,  1,32'h300,      0,32'h304,      0,32'h0,        32'h0));
        tbl.push_back(mk(0,0,1,32'hC0,       0,32'h0,        0,  0,32'h300,      1,32'h304,      0,32'h0,        32'h0));
        // redirect in REQ with acceptance: that response is dropped
        tbl.push_back(mk(0,1,0,32'h0,        1,32'h400,      0,  1,32'h304,      1,32'h400,      1,32'h300,      32'hC0));
        tbl.push_back(mk(0,0,1,32'hBEEF,     0,32'h0,        0,  0,32'h400,      0,32'h404,      0,32'h0,        32'h0));
        tbl.push_back(mk(0,1,0,32'h0,        0,32'h0,        0,  1,32'h400,      0,32'h404,      0,32'h0,        32'h0));
        tbl.push_back(mk(0,0,1,32'hC1,       0,32'h0,        0,  0,32'h400,      1,32'h404,      0,32'h0,        32'h0));
        // redirect in HOLD discards the skid entry
        tbl.push_back(mk(0,1,0,32'h0,        0,32'h0,        1,  1,32'h404,      0,32'h408,      1,32'h400,      32'hC1));
        tbl.push_back(mk(0,0,1,32'hC2,       0,32'h0,        1,  0,32'h404,      1,32'h408,      1,32'h400,      32'hC1));
        tbl.push_back(mk(0,0,0,32'h0,        1,32'h500,      1,  0,32'h408,      1,32'h500,      1,32'h400,      32'hC1));
        tbl.push_back(mk(0,0,0,32'h0,        0,32'h0,        0,  1,32'h500,      0,32'h504,      0,32'h0,        32'h0));
        // wrap-around from 0xFFFFFFFC
        tbl.push_back(mk(0,0,0,32'h0,        1,32'hFFFFFFFC, 0,  1,32'h500,      1,32'hFFFFFFFC, 0,32'h0,        32'h0));
        tbl.push_back(mk(0,1,0,32'h0,        0,32'h0,        0,  1,32'hFFFFFFFC, 0,32'h0,        0,32'h0,        32'h0));
        tbl.push_back(mk(0,0,1,32'hD0,       0,32'h0,        0,  0,32'hFFFFFFFC, 1,32'h0,        0,32'h0,        32'h0));
        tbl.push_back(mk(0,0,0,32'h0,        0,32'h0,        0,  1,32'h0,        0,32'h4,        1,32'hFFFFFFFC, 32'hD0));

        rst = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        redirect = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        foreach (tbl[i]) apply($sformatf("v%0d", i), tbl[i]);

        // Reset in the middle of a transaction with a stray response pulse.
        apply("rst_accept", mk(0,1,0,32'h0,  0,32'h0, 0,  1,32'h0, 0,32'h4, 0,32'h0, 32'h0));
        apply("rst_assert", mk(1,0,1,32'hEE, 0,32'h0, 0,  0,32'h0, 0,32'h4, 0,32'h0, 32'h0));
        v = mk(0,0,1,32'hEE, 0,32'h0, 0,  0,32'h0, 0,32'h4, 0,32'h0, 32'h0);
        v.chk_if = 1'b1;
        apply("rst_idle", v);
        apply("rst_first_req", mk(0,0,0,32'h0, 0,32'h0, 0,  1,32'h0, 0,32'h4, 0,32'h0, 32'h0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the RV32I core, sitting directly downstream of the 32-bit PC register. Reads the current PC, issues one instruction-memory request at a time, and captures the returned word into the IF/ID pipeline register. Computes the PC register's next value and load enable: sequential `+4` or an execute-stage redirect. A one-entry skid buffer absorbs a response that arrives while decode is stalled.

## Interface
- `ADDR_W`, default 32: PC and instruction-memory address width.
- `INSTR_W`, default 32: instruction width.

- `clk`, in, 1: single clock. All state updates on the rising edge.
- `rst`, in, 1: reset. Synchronous and active-high.
- `pc_q`, in, ADDR_W: current PC from the PC register (the register resets to 0).
- `pc_next`, out, ADDR_W: d input of the PC register.
- `pc_load`, out, 1: load enable of the PC register.
- `imem_req`, out, 1: request valid.
- `imem_addr`, out, ADDR_W: request address.
- `imem_ready`, in, 1: memory accepts the request this cycle.
- `imem_rvalid`, in, 1: response valid.
- `imem_rdata`, in, INSTR_W: response instruction.
- `redirect`, in, 1: branch/jump taken; flush and refetch.
- `redirect_pc`, in, ADDR_W: redirect target.
- `stall`, in, 1: decode cannot accept; hold IF/ID.
- `if_valid`, out, 1: IF/ID register holds a valid instruction.
- `if_pc`, out, ADDR_W: PC of the held instruction.
- `if_instr`, out, INSTR_W: the held instruction.

## Operation
- **States:** IDLE, REQ, WAIT, HOLD. There is at most one outstanding memory request.
- **Reset:**
  - State goes to IDLE. `if_valid`, `if_pc`, `if_instr`, the skid buffer and the drop flag all clear to 0.
  - `imem_req=0` and `pc_load=0`.
  - `imem_addr` follows `pc_q`.
  - `pc_next=pc_q+4`.
- **IDLE:** one cycle, then go to REQ.
- **REQ:**
  - Drive `imem_req=1` and `imem_addr=pc_q`.
  - If `imem_ready=1`, go to WAIT. Otherwise stay in REQ; the address may change only through a redirect.
- **WAIT:** on `imem_rvalid=1`:
  - If the drop flag is set: discard the response, clear drop, go to REQ. `pc_load` stays 0.
  - Else if IF/ID is free (`if_valid=0`, or `stall=0`): capture `if_pc=pc_q`, `if_instr=imem_rdata`, set `if_valid=1`. Assert `pc_load` with `pc_next=pc_q+4`. Go to REQ.
  - Else: store pc/instr in the skid buffer, assert `pc_load` with `+4`, go to HOLD.
- **HOLD:**
  - When `stall=0`, move the skid buffer into IF/ID (`if_valid=1`) and go to REQ.
  - No request is issued while in HOLD.
- **IF/ID consumption:** the IF/ID entry is consumed at a clock edge where `if_valid=1` and `stall=0`. If no new word is loaded that edge, `if_valid` goes to 0.
- **Redirect** (priority: `rst` > `redirect` > everything else):
  - `pc_load=1` and `pc_next={redirect_pc[ADDR_W-1:2],2'b00}`, in the same cycle.
  - `if_valid` is 0 next cycle regardless of `stall`. The skid buffer is invalidated.
  - In WAIT, or in REQ with `imem_ready=1` the same cycle: set drop and go to (or stay in) WAIT.
  - In REQ with `imem_ready=0`: stay in REQ (next address = target).
  - In HOLD: go to REQ.
  - `redirect` together with `imem_rvalid` in WAIT: the response is discarded, drop is not set, go to REQ.
- **Arithmetic:** `pc_q+4` wraps modulo 2^ADDR_W, so `0xFFFFFFFC` → `0x00000000`.
- **Reset mid-transaction:** any in-flight response is ignored. The first post-reset request is to `pc_q` (0).

## Timing
- Minimum fetch latency is 2 cycles (REQ, WAIT with `imem_rvalid` the cycle after acceptance). Peak throughput is 1 instruction per 2 cycles.
- `if_valid` rises the edge after `imem_rvalid`.
- `pc_load` is asserted for exactly one cycle per captured or skidded response, plus one cycle per redirect cycle.
- First `imem_req` after reset deassertion is on the 2nd cycle (IDLE → REQ).
- The skid buffer drains to IF/ID on the edge where `stall` is sampled 0 in HOLD. The next request follows one cycle later.

## Test plan
- **Reset:** assert `rst` mid-WAIT with `imem_rvalid` pulsing → all outputs 0 next cycle, IDLE, then `imem_req=1` with `imem_addr=0x0`.
- **Sequential fetch:** `imem_ready=1`, `rvalid` 1 cycle after acceptance, data `0xA0+n` → `if_pc` sequence 0x0, 0x4, 0x8 with matching `if_instr`, one `pc_load` each.
- **Variable latency:** `imem_ready` delayed 3 cycles, `rvalid` delayed 5 → same ordered output, `imem_addr` stable while waiting, no extra `pc_load`.
- **Stall with skid:** hold `stall=1` with `if_pc=0x4` valid while response for 0x8 arrives → HOLD, no `imem_req`. Release `stall` → `if_pc=0x8` next edge, then request 0xC.
- **Redirect:** redirect to `0x103` during WAIT → `pc_next=0x100`, `if_valid=0` next cycle, late response dropped, next capture has `if_pc=0x100`. Also cover `redirect` together with `rvalid` in the same cycle.
- **Wrap-around:** force `pc_q=0xFFFFFFFC` and capture → `pc_next=0x00000000`.
